// File: rtl/cpu65xx_intctl.sv
// Conditions the async interrupt/control pins for cpu65xx_core: synchronisers, NMI/S.O.
// edge detect, stretched core reset and a prioritised poll/acknowledge interrupt request.
module cpu65xx_intctl #(
  parameter int pSyncStages = 2,
  parameter int pResetHold  = 7
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Irq_n,
  input  logic Nmi_n,
  input  logic So_n,
  input  logic Rdy,
  input  logic IrqMask,
  input  logic PollEn,
  input  logic IntAck,
  output logic CoreRst,
  output logic RdySync,
  output logic IntPend,
  output logic IntIsNmi,
  output logic SoPulse
);

  localparam logic [7:0] LP_HOLD = 8'(pResetHold);

  typedef enum logic {ST_IDLE, ST_PEND} state_t;

  logic [pSyncStages-1:0] r_irq_sync, r_nmi_sync, r_so_sync, r_rdy_sync;
  logic                   r_nmi_prev, r_so_prev;
  logic [7:0]             r_rst_cnt;
  logic                   r_nmi_latch, r_int_pend, r_int_is_nmi, r_so_pulse;
  state_t                 r_state;

  logic w_irq_s, w_nmi_s, w_so_s;
  logic w_nmi_fall, w_so_fall, w_core_rst, w_irq_req, w_nmi_clr;

  // Synchroniser chains: inactive pin levels are loaded during reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_irq_sync <= '1;
      r_nmi_sync <= '1;
      r_so_sync  <= '1;
      r_rdy_sync <= '0;
      r_nmi_prev <= 1'b1;
      r_so_prev  <= 1'b1;
    end else begin
      r_irq_sync <= {r_irq_sync[pSyncStages-2:0], Irq_n};
      r_nmi_sync <= {r_nmi_sync[pSyncStages-2:0], Nmi_n};
      r_so_sync  <= {r_so_sync[pSyncStages-2:0], So_n};
      r_rdy_sync <= {r_rdy_sync[pSyncStages-2:0], Rdy};
      r_nmi_prev <= w_nmi_s;
      r_so_prev  <= w_so_s;
    end
  end

  assign w_irq_s    = r_irq_sync[pSyncStages-1];
  assign w_nmi_s    = r_nmi_sync[pSyncStages-1];
  assign w_so_s     = r_so_sync[pSyncStages-1];
  assign w_nmi_fall = r_nmi_prev & ~w_nmi_s;
  assign w_so_fall  = r_so_prev & ~w_so_s;

  always_ff @(posedge Clk) begin
    if (!Rst_n)
      r_rst_cnt <= LP_HOLD;
    else if (r_rst_cnt != 8'd0)
      r_rst_cnt <= r_rst_cnt - 8'd1;
  end

  assign w_core_rst = ~Rst_n | (r_rst_cnt != 8'd0);
  assign w_irq_req  = ~w_irq_s & ~IrqMask;
  assign w_nmi_clr  = IntAck & (r_state == ST_PEND) & r_int_is_nmi;

  // A new NMI edge beats a simultaneous acknowledge so it is never lost.
  always_ff @(posedge Clk) begin
    if (w_core_rst) begin
      r_state      <= ST_IDLE;
      r_nmi_latch  <= 1'b0;
      r_int_pend   <= 1'b0;
      r_int_is_nmi <= 1'b0;
      r_so_pulse   <= 1'b0;
    end else begin
      r_so_pulse <= w_so_fall;
      if (w_nmi_fall)
        r_nmi_latch <= 1'b1;
      else if (w_nmi_clr)
        r_nmi_latch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (PollEn && r_rdy_sync[pSyncStages-1] && (r_nmi_latch || w_irq_req)) begin
            r_state      <= ST_PEND;
            r_int_pend   <= 1'b1;
            r_int_is_nmi <= r_nmi_latch;
          end
        end
        ST_PEND: begin
          if (IntAck) begin
            r_state      <= ST_IDLE;
            r_int_pend   <= 1'b0;
            r_int_is_nmi <= 1'b0;
          end else if (r_nmi_latch || w_nmi_fall) begin
            r_int_is_nmi <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CoreRst  = w_core_rst;
  assign RdySync  = r_rdy_sync[pSyncStages-1];
  assign IntPend  = r_int_pend;
  assign IntIsNmi = r_int_is_nmi;
  assign SoPulse  = r_so_pulse;

endmodule
